// File: rtl/serial_mag_comparator.sv
// Multi-cycle unsigned magnitude comparator: walks two captured operands MSB-first,
// one bit per clock, and stops at the first differing bit with a one-hot result.
module serial_mag_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_res;

  // 1-bit compare cell, result ordered {gt, eq, lt}.
  function automatic logic [2:0] cmp_cell(input logic a, input logic b);
    return {a & ~b, ~(a ^ b), ~a & b};
  endfunction

  assign bit_res = cmp_cell(sa[WIDTH-1], sb[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sa           <= '0;
      sb           <= '0;
      cnt          <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      {GT, EQ, LT} <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa           <= A;
            sb           <= B;
            cnt          <= CNT_INIT;
            {GT, EQ, LT} <= 3'b000;
            busy         <= 1'b1;
            state        <= COMPARE;
          end
        end
        COMPARE: begin
          // A differing bit decides immediately; equal bits on the last position mean A==B.
          if (!bit_res[1] || cnt == CNT_ONE) begin
            {GT, EQ, LT} <= bit_res;
            done         <= 1'b1;
            state        <= DONE;
          end else begin
            sa  <= sa << 1;
            sb  <= sb << 1;
            cnt <= cnt - CNT_ONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and randomized bench for serial_mag_comparator at WIDTH=8 and WIDTH=1,
// using a queue of expected {result, latency} entries.
module tb_serial_mag_comparator;

  typedef struct packed {
    logic [2:0] res;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, gt8, eq8, lt8;
  logic       busy1, done1, gt1, eq1, lt1;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  serial_mag_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .GT(gt8), .EQ(eq8), .LT(lt8)
  );

  serial_mag_comparator #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .GT(gt1), .EQ(eq1), .LT(lt1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res_of(input bit w1);
    return w1 ? {gt1, eq1, lt1} : {gt8, eq8, lt8};
  endfunction

  // One operation: push the expectation, pulse start, wait (bounded) for done, pop and compare.
  // ign > 0 re-pulses start with A=00/B=FF so that it is sampled on edge ign while busy.
  task automatic run(input bit w1, input logic [7:0] a, input logic [7:0] b, input int ign);
    int         w;
    int         d;
    int         n;
    bit         found;
    logic [7:0] av, bv;
    exp_t       e;
    w     = w1 ? 1 : 8;
    av    = w1 ? {7'b0, a[0]} : a;
    bv    = w1 ? {7'b0, b[0]} : b;
    d     = w;
    found = 1'b0;
    for (int i = w - 1; i >= 0; i--) begin
      if (!found && (av[i] != bv[i])) begin
        d     = w - i;
        found = 1'b1;
      end
    end
    e.res = (av > bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001;
    e.lat = d + 1;
    sb_q.push_back(e);

    if (w1) begin
      a1 = a[0]; b1 = b[0]; start1 = 1'b1;
    end else begin
      a8 = a; b8 = b; start8 = 1'b1;
    end
    tick();
    start1 = 1'b0;
    start8 = 1'b0;
    n = 1;
    check("busy_after_start", w1 ? busy1 : busy8, 1);
    check("res_cleared_while_computing", res_of(w1), 3'b000);
    while (!(w1 ? done1 : done8) && n < 80) begin
      if (n == ign - 1) begin
        start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      tick();
      n++;
    end
    start8 = 1'b0;
    e = sb_q.pop_front();
    check("done_seen", w1 ? done1 : done8, 1);
    check("busy_at_done", w1 ? busy1 : busy8, 1);
    check("result", res_of(w1), e.res);
    check("latency_edges", n, e.lat);
    tick();
    check("done_single_pulse", w1 ? done1 : done8, 0);
    check("busy_low_in_idle", w1 ? busy1 : busy8, 0);
    check("result_holds", res_of(w1), e.res);
    tick();
    check("no_second_done", w1 ? done1 : done8, 0);
    check("result_still_holds", res_of(w1), e.res);
  endtask

  initial begin
    logic [7:0] ra, rb;
    int         mode;

    // Reset held with start asserted.
    rst = 1'b1; start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    tick(); tick(); tick();
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_res", res_of(0), 3'b000);
    check("rst_res_w1", res_of(1), 3'b000);
    rst = 1'b0; start8 = 1'b0;
    tick(); tick(); tick();
    check("post_rst_busy", busy8, 0);
    check("post_rst_done", done8, 0);
    check("post_rst_res", res_of(0), 3'b000);

    // MSB decides, LSB decides, equal operands.
    run(0, 8'h80, 8'h7F, 0);
    run(0, 8'h54, 8'h55, 0);
    run(0, 8'hA5, 8'hA5, 0);
    // Mid-bit decision with an ignored start on edge 3.
    run(0, 8'h3C, 8'h34, 3);

    // Asynchronous reset in the middle of a compare.
    a8 = 8'h01; b8 = 8'h00; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    check("midrun_busy", busy8, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", busy8, 0);
    check("async_rst_done", done8, 0);
    check("async_rst_res", res_of(0), 3'b000);
    tick();
    rst = 1'b0;
    tick();
    check("after_rst_idle", busy8, 0);
    run(0, 8'h01, 8'h00, 0);

    // WIDTH=1 directed corners.
    run(1, 8'h01, 8'h00, 0);
    run(1, 8'h00, 8'h01, 0);
    run(1, 8'h01, 8'h01, 0);
    run(1, 8'h00, 8'h00, 0);

    // Randomized sweep, biased toward equal and single-bit-different pairs.
    for (int k = 0; k < 1000; k++) begin
      ra   = 8'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run(0, ra, rb, 0);
    end
    for (int k = 0; k < 1000; k++) begin
      run(1, 8'($urandom_range(0, 1)), 8'($urandom_range(0, 1)), 0);
    end

    check("scoreboard_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
